// File: rtl/vldrdy_fork_n_if.sv
// Upstream and downstream handshake bundle for the N-way valid/ready fork.
interface vldrdy_fork_n_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
);
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic [N-1:0]  up_mask;
    logic [N-1:0]  dn_valid;
    logic [N-1:0]  dn_ready;
    logic [DW-1:0] dn_data;
    logic [N-1:0]  pending;
    logic [CW-1:0] xfer_cnt;

    modport slave (
        input  up_valid, up_data, up_mask, dn_ready,
        output up_ready, dn_valid, dn_data, pending, xfer_cnt
    );

    modport master (
        output up_valid, up_data, up_mask, dn_ready,
        input  up_ready, dn_valid, dn_data, pending, xfer_cnt
    );
endinterface

// File: rtl/vldrdy_fork_n.sv
// Forks one upstream valid/ready transfer to a masked set of N channels;
// each channel fires once, and upstream completes when the last one fires.
module vldrdy_fork_n #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic           clock,
    input  logic           resetn,
    vldrdy_fork_n_if.slave bus
);
    logic [N-1:0]  done_q;
    logic [N-1:0]  done_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [N-1:0]  dn_valid_c;
    logic [N-1:0]  dn_fire_c;
    logic [N-1:0]  need_c;
    logic [N-1:0]  pending_c;
    logic          up_ready_c;
    logic [DW-1:0] data_c;

    // Handshake decode and next-state; an upstream fire wins over channel fires.
    always_comb begin
        dn_valid_c = '0;
        dn_fire_c  = '0;
        need_c     = '0;
        pending_c  = '0;
        up_ready_c = 1'b0;
        done_d     = done_q;
        cnt_d      = cnt_q;

        dn_valid_c = {N{bus.up_valid}} & bus.up_mask & ~done_q;
        dn_fire_c  = dn_valid_c & bus.dn_ready;
        need_c     = bus.up_mask & ~done_q & ~dn_fire_c;
        pending_c  = {N{bus.up_valid}} & bus.up_mask & ~done_q;
        up_ready_c = bus.up_valid & (need_c == '0);

        if (up_ready_c) begin
            done_d = '0;
            cnt_d  = cnt_q + CW'(1);
        end else begin
            done_d = done_q | dn_fire_c;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            done_q <= '0;
            cnt_q  <= '0;
        end else begin
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_c       = bus.up_data;
    assign bus.dn_data  = data_c;
    assign bus.dn_valid = dn_valid_c;
    assign bus.up_ready = up_ready_c;
    assign bus.pending  = pending_c;
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_vldrdy_fork_n.sv
// Bench for vldrdy_fork_n: set-based reference model, fire scoreboard and directed scenarios.
module tb_vldrdy_fork_n;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    vldrdy_fork_n_if #(.N(N), .DW(DW), .CW(CW)) bus ();
    vldrdy_fork_n #(.N(N), .DW(DW), .CW(CW)) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    vldrdy_fork_n_if #(.N(4), .DW(8), .CW(4)) bus4 ();
    vldrdy_fork_n #(.N(4), .DW(8), .CW(4)) u_dut4 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the set of channels already served for the current transfer.
    logic [N-1:0] served_m;
    int unsigned  cnt_m;

    function automatic logic [N-1:0] owed();
        return bus.up_valid ? (bus.up_mask & ~served_m) : '0;
    endfunction

    function automatic logic done_exp();
        return bus.up_valid && ((bus.up_mask & ~served_m & ~bus.dn_ready) == '0);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            served_m <= '0;
            cnt_m    <= 0;
        end else if (done_exp()) begin
            served_m <= '0;
            cnt_m    <= cnt_m + 1;
        end else begin
            served_m <= served_m | (owed() & bus.dn_ready);
        end
    end

    // Per-cycle compare, fire scoreboard and upstream protocol checks.
    int            fires_q [N];
    logic          pv_q;
    logic          prdy_q;
    logic [N-1:0]  pm_q;
    logic [DW-1:0] pd_q;

    always @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) fires_q[i] <= 0;
            pv_q   <= 1'b0;
            prdy_q <= 1'b0;
            pm_q   <= '0;
            pd_q   <= '0;
        end else begin
            chk("dn_valid", 64'(bus.dn_valid), 64'(owed()));
            chk("up_ready", 64'(bus.up_ready), 64'(done_exp()));
            chk("pending", 64'(bus.pending), 64'(owed()));
            chk("xfer_cnt", 64'(bus.xfer_cnt), 64'(CW'(cnt_m)));
            chk("dn_data", 64'(bus.dn_data), 64'(bus.up_data));
            if (pv_q && !prdy_q) begin
                chk("proto_valid_held", 64'(bus.up_valid), 64'(1));
                chk("proto_stable", 64'({bus.up_mask, bus.up_data}), 64'({pm_q, pd_q}));
            end
            for (int i = 0; i < N; i++) begin
                if (bus.up_valid && bus.up_ready) begin
                    chk($sformatf("sb_fires_ch%0d", i),
                        64'(fires_q[i] + int'(bus.dn_valid[i] & bus.dn_ready[i])),
                        64'(bus.up_mask[i]));
                    fires_q[i] <= 0;
                end else begin
                    fires_q[i] <= fires_q[i] + int'(bus.dn_valid[i] & bus.dn_ready[i]);
                end
            end
            pv_q   <= bus.up_valid;
            prdy_q <= bus.up_ready;
            pm_q   <= bus.up_mask;
            pd_q   <= bus.up_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        int   cyc;

        resetn        = 1'b0;
        bus.up_valid  = 1'b1;
        bus.up_mask   = 4'b1010;
        bus.up_data   = 32'h1234_5678;
        bus.dn_ready  = '0;
        bus4.up_valid = 1'b0;
        bus4.up_mask  = '0;
        bus4.up_data  = '0;
        bus4.dn_ready = '0;

        // Outputs under reset follow the inputs with no progress recorded.
        #3;
        chk("rst_dn_valid", 64'(bus.dn_valid), 64'(4'b1010));
        chk("rst_pending", 64'(bus.pending), 64'(4'b1010));
        chk("rst_up_ready", 64'(bus.up_ready), 64'(0));
        chk("rst_xfer_cnt", 64'(bus.xfer_cnt), 64'(0));
        bus.up_valid = 1'b0;
        step();
        resetn = 1'b1;

        // All four channels ready: completes in one cycle.
        bus.up_mask  = 4'b1111;
        bus.dn_ready = 4'b1111;
        bus.up_data  = 32'hA5A5_0001;
        bus.up_valid = 1'b1;
        @(negedge clock);
        chk("t1_up_ready", 64'(bus.up_ready), 64'(1));
        chk("t1_dn_valid", 64'(bus.dn_valid), 64'(4'b1111));
        chk("t1_cnt_before", 64'(bus.xfer_cnt), 64'(0));
        step();
        bus.up_valid = 1'b0;
        bus.dn_ready = '0;
        #1;
        chk("t1_cnt_after", 64'(bus.xfer_cnt), 64'(1));

        // Channel 0 at cycle 0, channel 2 at cycle 3.
        step();
        bus.up_mask  = 4'b0101;
        bus.up_data  = 32'hBEEF_0002;
        bus.dn_ready = 4'b0001;
        bus.up_valid = 1'b1;
        @(negedge clock);
        chk("t2_c0_dn_valid", 64'(bus.dn_valid), 64'(4'b0101));
        chk("t2_c0_up_ready", 64'(bus.up_ready), 64'(0));
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.dn_ready = (c == 3) ? 4'b0100 : 4'b0000;
            @(negedge clock);
            chk($sformatf("t2_c%0d_dn_valid", c), 64'(bus.dn_valid), 64'(4'b0100));
            chk($sformatf("t2_c%0d_pending", c), 64'(bus.pending), 64'(4'b0100));
            chk($sformatf("t2_c%0d_up_ready", c), 64'(bus.up_ready), 64'(c == 3));
        end
        step();
        bus.up_valid = 1'b0;
        bus.dn_ready = '0;

        // Three dropped transfers back to back.
        bus.up_mask  = '0;
        bus.up_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.up_data = 32'(c + 16);
            @(negedge clock);
            chk("t3_up_ready", 64'(bus.up_ready), 64'(1));
            chk("t3_dn_valid", 64'(bus.dn_valid), 64'(0));
            step();
        end
        bus.up_valid = 1'b0;
        #1;
        chk("t3_cnt", 64'(bus.xfer_cnt), 64'(5));

        // Narrow counter wraps after sixteen transfers.
        bus4.up_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 15) chk("cw4_after15", 64'(bus4.xfer_cnt), 64'(15));
            if (k == 16) chk("cw4_after16", 64'(bus4.xfer_cnt), 64'(0));
            if (k == 17) chk("cw4_after17", 64'(bus4.xfer_cnt), 64'(1));
        end
        bus4.up_valid = 1'b0;

        // Reset pulse between edges discards partial progress.
        bus.up_mask  = 4'b1111;
        bus.up_data  = 32'hC0DE_0003;
        bus.dn_ready = 4'b0011;
        bus.up_valid = 1'b1;
        @(negedge clock);
        chk("t5_dn_valid_first", 64'(bus.dn_valid), 64'(4'b1111));
        step();
        bus.dn_ready = '0;
        @(negedge clock);
        chk("t5_dn_valid_partial", 64'(bus.dn_valid), 64'(4'b1100));
        step();
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_dn_valid", 64'(bus.dn_valid), 64'(4'b1111));
        chk("t5_rst_pending", 64'(bus.pending), 64'(4'b1111));
        chk("t5_rst_cnt", 64'(bus.xfer_cnt), 64'(0));
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("t5_rel_dn_valid", 64'(bus.dn_valid), 64'(4'b1111));
        step();
        bus.dn_ready = 4'b1111;
        @(negedge clock);
        chk("t5_up_ready", 64'(bus.up_ready), 64'(1));
        step();
        bus.up_valid = 1'b0;
        bus.dn_ready = '0;
        #1;
        chk("t5_cnt", 64'(bus.xfer_cnt), 64'(1));

        // Random masks and random per-cycle readiness.
        for (int t = 0; t < 3000; t++) begin
            if (t % 7 == 0) step();
            bus.up_mask  = N'($urandom);
            bus.up_data  = $urandom;
            bus.up_valid = 1'b1;
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 200) begin
                bus.dn_ready = N'($urandom);
                @(negedge clock);
                got = bus.up_ready;
                step();
                cyc++;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_timeout: transfer %0d got no up_ready within %0d cycles", t, cyc);
            end
            bus.up_valid = 1'b0;
            bus.dn_ready = '0;
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
